// File: rtl/stream_block_stager_if.sv
// Stream bundle for stream_block_stager: input AXI-stream, row path to the
// transform core, result path from the core, and output AXI-stream.
// The slave modport is the stager's view; the master modport is the
// surrounding environment (source, core and sink) driving the stager.
interface stream_block_stager_if #(
    parameter int DATA_W   = 64,
    parameter int SAMPLE_W = 16,
    parameter int N        = 8
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int ROW_W  = N * SAMPLE_W;

    logic              in_t_valid;
    logic              in_t_ready;
    logic [DATA_W-1:0] in_t_data;
    logic [KEEP_W-1:0] in_t_keep;
    logic              in_t_last;

    logic              row_valid;
    logic              row_ready;
    logic [ROW_W-1:0]  row_data;

    logic              res_valid;
    logic              res_ready;
    logic [ROW_W-1:0]  res_data;

    logic              out_t_valid;
    logic              out_t_ready;
    logic [DATA_W-1:0] out_t_data;
    logic [KEEP_W-1:0] out_t_keep;
    logic [KEEP_W-1:0] out_t_strb;
    logic              out_t_last;

    modport slave (
        input  in_t_valid, in_t_data, in_t_keep, in_t_last,
        output in_t_ready,
        output row_valid, row_data,
        input  row_ready,
        input  res_valid, res_data,
        output res_ready,
        output out_t_valid, out_t_data, out_t_keep, out_t_strb, out_t_last,
        input  out_t_ready
    );

    modport master (
        output in_t_valid, in_t_data, in_t_keep, in_t_last,
        input  in_t_ready,
        input  row_valid, row_data,
        output row_ready,
        output res_valid, res_data,
        input  res_ready,
        input  out_t_valid, out_t_data, out_t_keep, out_t_strb, out_t_last,
        output out_t_ready
    );
endinterface

// File: rtl/stream_block_stager.sv
// Packs stream beats into N-sample rows for a row-based 2D transform core,
// zero-pads short frames to whole NxN blocks, buffers result rows and
// re-serialises them onto the output stream with t_last at frame end.
// TAG_DEPTH and RES_DEPTH must be powers of two and at least 2.
module stream_block_stager #(
    parameter int DATA_W    = 64,
    parameter int SAMPLE_W  = 16,
    parameter int N         = 8,
    parameter int RES_DEPTH = 4,
    parameter int TAG_DEPTH = 4
) (
    input  logic aclk,
    input  logic aresetn,
    stream_block_stager_if.slave bus
);
    localparam int LANES  = DATA_W / SAMPLE_W;
    localparam int BPR    = N / LANES;
    localparam int ROW_W  = N * SAMPLE_W;
    localparam int KEEP_W = DATA_W / 8;
    localparam int BEAT_W = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int ROWC_W = (N > 1) ? $clog2(N) : 1;
    localparam int RES_AW = $clog2(RES_DEPTH);
    localparam int TAG_AW = $clog2(TAG_DEPTH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BPR - 1);
    localparam logic [ROWC_W-1:0] LAST_ROW  = ROWC_W'(N - 1);

    typedef enum logic [1:0] {FILL, PRESENT, PAD} state_t;

    state_t              state, state_next;
    logic                active;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [ROWC_W-1:0]   row_cnt;
    logic [ROW_W-1:0]    row_reg;
    logic                frame_ended;
    logic [DATA_W-1:0]   in_masked;
    logic                block_start, in_ready, in_accept, row_fire;

    logic [TAG_DEPTH-1:0] tag_last;
    logic [TAG_AW:0]      tag_wp, tag_rp;
    logic [TAG_AW-1:0]    tag_pend_idx;
    logic                 tag_full, tag_pop;

    logic [ROW_W-1:0]     res_mem [RES_DEPTH];
    logic [RES_AW:0]      res_wp, res_rp;
    logic                 res_full, res_empty, res_push, res_pop;
    logic [ROW_W-1:0]     res_head;

    logic [BEAT_W-1:0]    obeat;
    logic [ROWC_W-1:0]    orow;
    logic                 out_valid, out_fire, row_end;
    logic [DATA_W-1:0]    out_data;

    assign block_start  = (row_cnt == '0) && (beat_cnt == '0);
    assign tag_full     = (tag_wp[TAG_AW] != tag_rp[TAG_AW]) &&
                          (tag_wp[TAG_AW-1:0] == tag_rp[TAG_AW-1:0]);
    assign tag_pend_idx = tag_wp[TAG_AW-1:0] - 1'b1;
    assign in_ready     = active && (state == FILL) && !(block_start && tag_full);
    assign in_accept    = bus.in_t_valid && in_ready;
    assign row_fire     = (state != FILL) && bus.row_ready;

    assign res_full  = (res_wp[RES_AW] != res_rp[RES_AW]) &&
                       (res_wp[RES_AW-1:0] == res_rp[RES_AW-1:0]);
    assign res_empty = (res_wp == res_rp);
    assign res_push  = bus.res_valid && bus.res_ready;
    assign res_head  = res_mem[res_rp[RES_AW-1:0]];

    assign out_valid = !res_empty;
    assign out_fire  = out_valid && bus.out_t_ready;
    assign row_end   = (obeat == LAST_BEAT);
    assign res_pop   = out_fire && row_end;
    assign tag_pop   = res_pop && (orow == LAST_ROW);

    assign bus.in_t_ready  = in_ready;
    assign bus.row_valid   = (state != FILL);
    assign bus.row_data    = row_reg;
    assign bus.res_ready   = active && !res_full;
    assign bus.out_t_valid = out_valid;
    assign bus.out_t_data  = out_data;
    assign bus.out_t_keep  = {KEEP_W{out_valid}};
    assign bus.out_t_strb  = {KEEP_W{out_valid}};
    assign bus.out_t_last  = out_valid && row_end && (orow == LAST_ROW) &&
                             tag_last[tag_rp[TAG_AW-1:0]];

    // Zero every input byte whose keep bit is clear.
    always_comb begin
        in_masked = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            if (bus.in_t_keep[i]) in_masked[i*8 +: 8] = bus.in_t_data[i*8 +: 8];
        end
    end

    // Select the current beat of the head result row.
    always_comb begin
        out_data = '0;
        for (int b = 0; b < BPR; b++) begin
            if (out_valid && (obeat == BEAT_W'(b))) out_data = res_head[b*DATA_W +: DATA_W];
        end
    end

    // Holds both ready outputs low until the first edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) active <= 1'b0;
        else          active <= 1'b1;
    end

    // Input FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= FILL;
        else          state <= state_next;
    end

    // Input FSM: fill a row, present it, then pad out a short block.
    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (in_accept && (beat_cnt == LAST_BEAT || bus.in_t_last)) state_next = PRESENT;
            end
            PRESENT: begin
                if (row_fire) state_next = (frame_ended && row_cnt != LAST_ROW) ? PAD : FILL;
            end
            PAD: begin
                if (row_fire && row_cnt == LAST_ROW) state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    // Row assembly and beat/row counters; the row register is cleared once handed over.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt    <= '0;
            row_cnt     <= '0;
            row_reg     <= '0;
            frame_ended <= 1'b0;
        end else begin
            if (in_accept) begin
                for (int b = 0; b < BPR; b++) begin
                    if (beat_cnt == BEAT_W'(b)) row_reg[b*DATA_W +: DATA_W] <= in_masked;
                end
                beat_cnt <= (beat_cnt == LAST_BEAT || bus.in_t_last) ? '0 : beat_cnt + 1'b1;
            end
            if (row_fire) begin
                row_reg <= '0;
                row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
            end
            if (in_accept && bus.in_t_last)         frame_ended <= 1'b1;
            else if (row_fire && state_next == FILL) frame_ended <= 1'b0;
        end
    end

    // Block tag FIFO: one entry per block in flight, its bit marks the frame's final block.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tag_last <= '0;
            tag_wp   <= '0;
            tag_rp   <= '0;
        end else begin
            if (in_accept && block_start) begin
                tag_last[tag_wp[TAG_AW-1:0]] <= bus.in_t_last;
                tag_wp <= tag_wp + 1'b1;
            end else if (in_accept && bus.in_t_last) begin
                tag_last[tag_pend_idx] <= 1'b1;
            end
            if (tag_pop) tag_rp <= tag_rp + 1'b1;
        end
    end

    // Result row storage; contents are never observed while the FIFO is empty.
    always_ff @(posedge aclk) begin
        if (res_push) res_mem[res_wp[RES_AW-1:0]] <= bus.res_data;
    end

    // Result FIFO pointers and output beat/row position within the block.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            res_wp <= '0;
            res_rp <= '0;
            obeat  <= '0;
            orow   <= '0;
        end else begin
            if (res_push) res_wp <= res_wp + 1'b1;
            if (res_pop)  res_rp <= res_rp + 1'b1;
            if (out_fire) begin
                obeat <= row_end ? '0 : obeat + 1'b1;
                if (row_end) orow <= (orow == LAST_ROW) ? '0 : orow + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stream_block_stager.sv
// Randomised bench for stream_block_stager: source, passthrough core with
// latency and sink, all checked against a frame-level sample model.
module tb_stream_block_stager;
    localparam int DATA_W    = 64;
    localparam int SAMPLE_W  = 16;
    localparam int N         = 8;
    localparam int RES_DEPTH = 4;
    localparam int TAG_DEPTH = 4;
    localparam int LANES     = DATA_W / SAMPLE_W;
    localparam int BPR       = N / LANES;
    localparam int ROW_W     = N * SAMPLE_W;
    localparam int KEEP_W    = DATA_W / 8;
    localparam int SB        = SAMPLE_W / 8;
    localparam int BLK_BEATS = N * BPR;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    typedef struct {
        logic [ROW_W-1:0] data;
        int               due;
    } core_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;

    stream_block_stager_if #(.DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W), .N(N)) bus ();

    stream_block_stager #(
        .DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W), .N(N),
        .RES_DEPTH(RES_DEPTH), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus)
    );

    // Free-running clock.
    always #5 aclk = ~aclk;

    beat_t in_q[$];
    beat_t exp_q[$];
    core_t core_q[$];

    int vectors, miscompares, cyc;
    int core_lat, row_pct, out_pct;
    int res_cnt, out_beats, in_acc, res_pushes;
    bit in_fire, row_fire, res_fire, out_fire;
    bit row_hold, core_hold, lat_probe;
    logic [ROW_W-1:0]  row_cap;
    logic              prev_out_valid, prev_out_fire, prev_out_last;
    logic [DATA_W-1:0] prev_out_data;

    task automatic check_output(input string tag, input logic [ROW_W-1:0] obs,
                                input logic [ROW_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queues one frame for the source and appends the expected output beats.
    task automatic apply_stimulus(input int nbeats, input bit with_last, input bit counting,
                                  input int drop_pct, input logic [LANES-1:0] last_lanes);
        logic [SAMPLE_W-1:0] flat[$];
        beat_t bt;
        int total;
        for (int b = 0; b < nbeats; b++) begin
            bt.data = {$urandom, $urandom};
            bt.keep = '0;
            bt.last = with_last && (b == nbeats - 1);
            for (int l = 0; l < LANES; l++) begin
                logic lane_on;
                if (counting) bt.data[l*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(b * LANES + l);
                lane_on = ($urandom_range(99) >= drop_pct);
                if (b == nbeats - 1) lane_on = lane_on && last_lanes[l];
                if (lane_on) bt.keep[l*SB +: SB] = '1;
                flat.push_back(lane_on ? bt.data[l*SAMPLE_W +: SAMPLE_W] : '0);
            end
            in_q.push_back(bt);
        end
        total = ((flat.size() + N * N - 1) / (N * N)) * N * N;
        while (flat.size() < total) flat.push_back('0);
        for (int k = 0; k < total / LANES; k++) begin
            bt.keep = '1;
            bt.last = with_last && (k == total / LANES - 1);
            for (int l = 0; l < LANES; l++) bt.data[l*SAMPLE_W +: SAMPLE_W] = flat[k*LANES + l];
            exp_q.push_back(bt);
        end
    endtask

    // One clock of source, core and sink activity, sampled on the falling edge.
    task automatic step();
        beat_t e;
        @(negedge aclk);
        cyc++;
        if (in_fire) begin
            void'(in_q.pop_front());
            in_acc++;
            if (lat_probe && in_acc == BPR - 1) check_output("row_valid_early", bus.row_valid, 1'b0);
            if (lat_probe && in_acc == BPR) check_output("row_valid_latency", bus.row_valid, 1'b1);
        end
        if (row_fire) core_q.push_back('{data: row_cap, due: cyc + core_lat});
        if (res_fire) begin
            void'(core_q.pop_front());
            res_cnt++;
            res_pushes++;
            if (lat_probe && res_pushes == 1) check_output("out_valid_latency", bus.out_t_valid, 1'b1);
        end
        if (out_fire) begin
            out_beats++;
            if (out_beats % BPR == 0) res_cnt--;
        end
        check_output("res_ready", bus.res_ready, res_cnt < RES_DEPTH);
        check_output("out_valid", bus.out_t_valid, res_cnt != 0);
        if (prev_out_valid && !prev_out_fire) begin
            check_output("stall_data", bus.out_t_data, prev_out_data);
            check_output("stall_last", bus.out_t_last, prev_out_last);
        end

        bus.in_t_valid = (in_q.size() != 0);
        if (in_q.size() != 0) begin
            bus.in_t_data = in_q[0].data;
            bus.in_t_keep = in_q[0].keep;
            bus.in_t_last = in_q[0].last;
        end else begin
            bus.in_t_data = '0;
            bus.in_t_keep = '0;
            bus.in_t_last = 1'b0;
        end
        bus.row_ready = !row_hold && ($urandom_range(99) < row_pct);
        if (!core_hold && core_q.size() != 0 && core_q[0].due <= cyc) begin
            bus.res_valid = 1'b1;
            bus.res_data  = core_q[0].data;
        end else begin
            bus.res_valid = 1'b0;
            bus.res_data  = '0;
        end
        bus.out_t_ready = ($urandom_range(99) < out_pct);

        in_fire  = bus.in_t_valid && bus.in_t_ready;
        row_fire = bus.row_valid && bus.row_ready;
        row_cap  = bus.row_data;
        res_fire = bus.res_valid && bus.res_ready;
        out_fire = bus.out_t_valid && bus.out_t_ready;
        if (out_fire) begin
            check_output("beat_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_output("out_data", bus.out_t_data, e.data);
                check_output("out_last", bus.out_t_last, e.last);
            end
            check_output("out_keep", bus.out_t_keep, {KEEP_W{1'b1}});
            check_output("out_strb", bus.out_t_strb, {KEEP_W{1'b1}});
        end
        prev_out_valid = bus.out_t_valid;
        prev_out_fire  = out_fire;
        prev_out_data  = bus.out_t_data;
        prev_out_last  = bus.out_t_last;
    endtask

    // Asserts reset on a falling edge, checks every output is zero, releases two cycles later.
    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        bus.in_t_valid = 1'b0; bus.in_t_data = '0; bus.in_t_keep = '0; bus.in_t_last = 1'b0;
        bus.row_ready = 1'b0; bus.res_valid = 1'b0; bus.res_data = '0; bus.out_t_ready = 1'b0;
        in_q.delete(); exp_q.delete(); core_q.delete();
        in_fire = 0; row_fire = 0; res_fire = 0; out_fire = 0;
        res_cnt = 0; out_beats = 0; in_acc = 0; res_pushes = 0;
        prev_out_valid = 1'b0; prev_out_fire = 1'b0;
        #1;
        check_output("rst_in_ready", bus.in_t_ready, 1'b0);
        check_output("rst_row_valid", bus.row_valid, 1'b0);
        check_output("rst_row_data", bus.row_data, '0);
        check_output("rst_res_ready", bus.res_ready, 1'b0);
        check_output("rst_out_valid", bus.out_t_valid, 1'b0);
        check_output("rst_out_data", bus.out_t_data, '0);
        check_output("rst_out_keep", bus.out_t_keep, '0);
        check_output("rst_out_strb", bus.out_t_strb, '0);
        check_output("rst_out_last", bus.out_t_last, 1'b0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    function automatic bit idle();
        return in_q.size() == 0 && core_q.size() == 0 && exp_q.size() == 0 &&
               res_cnt == 0 && !bus.row_valid;
    endfunction

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && !idle(); i++) step();
        check_output({tag, "_beats_left"}, exp_q.size(), 0);
        check_output({tag, "_inputs_left"}, in_q.size(), 0);
    endtask

    // Upper bound on total run time.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence of scenarios.
    initial begin
        int n;
        logic [ROW_W-1:0] rd;
        vectors = 0; miscompares = 0; cyc = 0;
        core_lat = 1; row_pct = 100; out_pct = 100;
        row_hold = 0; core_hold = 0; lat_probe = 0;
        do_reset();

        // Full counting frame through a passthrough core, with latency probes.
        lat_probe = 1;
        apply_stimulus(16, 1'b1, 1'b1, 0, '1);
        drain("t1", 400);
        lat_probe = 0;

        // Short frame ending mid-row with the final two lanes disabled.
        apply_stimulus(5, 1'b1, 1'b0, 0, 4'b0011);
        drain("t2", 400);

        // Random frames, stalled sink and slow core.
        core_lat = 7; row_pct = 70; out_pct = 30;
        for (int f = 0; f < 6; f++) apply_stimulus($urandom_range(1, 40), 1'b1, 1'b0, 20, '1);
        apply_stimulus(2 * BLK_BEATS, 1'b0, 1'b0, 0, '1);
        apply_stimulus($urandom_range(1, 40), 1'b1, 1'b0, 20, '1);
        drain("t3", 8000);

        // Core refuses a presented row for 20 cycles.
        core_lat = 2; row_pct = 100; out_pct = 100;
        row_hold = 1;
        apply_stimulus(16, 1'b1, 1'b0, 0, '1);
        for (int i = 0; i < 50 && !bus.row_valid; i++) step();
        check_output("t4_row_valid", bus.row_valid, 1'b1);
        rd = bus.row_data;
        n = in_q.size();
        repeat (20) begin
            step();
            check_output("t4_row_stable", bus.row_data, rd);
            check_output("t4_in_ready", bus.in_t_ready, 1'b0);
        end
        check_output("t4_no_accept", in_q.size(), n);
        row_hold = 0;
        drain("t4", 400);

        // Five blocks with results withheld: the fifth must wait for a tag slot.
        core_hold = 1;
        for (int b = 0; b < 5; b++) apply_stimulus(BLK_BEATS, 1'b0, 1'b0, 0, '1);
        for (int i = 0; i < 400 && in_q.size() > BLK_BEATS; i++) step();
        repeat (10) step();
        check_output("t5_stalled_beats", in_q.size(), BLK_BEATS);
        check_output("t5_in_ready", bus.in_t_ready, 1'b0);
        core_hold = 0;
        for (int i = 0; i < 400 && in_q.size() >= BLK_BEATS; i++) step();
        check_output("t5_resumed", in_q.size() < BLK_BEATS, 1'b1);
        check_output("t5_resume_after_pop", out_beats >= BLK_BEATS, 1'b1);
        drain("t5", 1000);

        // Reset in the middle of a block, then a fresh frame.
        core_lat = 3;
        apply_stimulus(16, 1'b1, 1'b0, 0, '1);
        repeat (5) step();
        do_reset();
        apply_stimulus(11, 1'b1, 1'b0, 10, '1);
        drain("t6", 400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
